// File: rtl/alarm_ctrl_if.sv
// Bundle of the timekeeping inputs, user requests and buzzer-side outputs
// that connects the alarm sequencer to its surroundings.
interface alarm_ctrl_if;
  logic       min_tick;
  logic [6:0] tmin;
  logic [6:0] thrs;
  logic [6:0] amin;
  logic [6:0] ahrs;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic       buzz;
  logic       snoozing;
  logic [6:0] snz_min;
  logic [6:0] snz_hrs;
  logic [2:0] snz_cnt;

  modport master (
    output min_tick, tmin, thrs, amin, ahrs, alarm_en, snooze, stop,
    input  buzz, snoozing, snz_min, snz_hrs, snz_cnt
  );

  modport slave (
    input  min_tick, tmin, thrs, amin, ahrs, alarm_en, snooze, stop,
    output buzz, snoozing, snz_min, snz_hrs, snz_cnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm buzzer sequencer: idle / ringing / snoozed phases with stop, snooze,
// snooze-target wrap across hour and day, and ring timeout.
module alarm_ctrl #(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_MIN   = 2,
  parameter int MAX_SNOOZE = 3
) (
  input  logic         clk,
  input  logic         reset,
  alarm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

  localparam logic [7:0] SNOOZE_INC = 8'(SNOOZE_MIN);
  localparam logic [3:0] RING_LAST  = 4'(RING_MIN - 1);
  localparam logic [2:0] SNZ_LIMIT  = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic [2:0] snz_cnt_q, snz_cnt_d;
  logic [6:0] snz_min_q, snz_min_d;
  logic [6:0] snz_hrs_q, snz_hrs_d;
  logic       fired_q, fired_d;
  logic       buzz_q, snoozing_q;
  logic       match_s, snz_hit_s, quit_s;
  logic [13:0] target_s;

  // Current time plus the snooze interval, wrapped at 60 minutes and 24 hours.
  function automatic logic [13:0] snooze_target(input logic [6:0] m_in, input logic [6:0] h_in);
    logic [7:0] m;
    logic [7:0] h;
    m = {1'b0, m_in} + SNOOZE_INC;
    if (m >= 8'd60) begin
      m = m - 8'd60;
      h = {1'b0, h_in} + 8'd1;
    end else begin
      h = {1'b0, h_in};
    end
    if (h == 8'd24) begin
      h = 8'd0;
    end else begin
      h = h;
    end
    return {h[6:0], m[6:0]};
  endfunction

  assign match_s   = (bus.tmin == bus.amin) && (bus.thrs == bus.ahrs);
  assign snz_hit_s = (bus.tmin == snz_min_q) && (bus.thrs == snz_hrs_q);
  assign quit_s    = bus.stop || !bus.alarm_en;
  assign target_s  = snooze_target(bus.tmin, bus.thrs);

  // Next-state and datapath update; fired blocks re-trigger within one matching minute.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_min_d  = snz_min_q;
    snz_hrs_d  = snz_hrs_q;
    fired_d    = match_s ? fired_q : 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.alarm_en && match_s && !fired_q) begin
          state_d    = ST_RINGING;
          ring_cnt_d = 4'd0;
          snz_cnt_d  = 3'd0;
          fired_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (quit_s) begin
          state_d   = ST_IDLE;
          snz_cnt_d = 3'd0;
        end else if (bus.snooze && (snz_cnt_q < SNZ_LIMIT)) begin
          state_d   = ST_SNOOZED;
          snz_cnt_d = snz_cnt_q + 3'd1;
          snz_min_d = target_s[6:0];
          snz_hrs_d = target_s[13:7];
        end else if (bus.min_tick && (ring_cnt_q == RING_LAST)) begin
          state_d   = ST_IDLE;
          snz_cnt_d = 3'd0;
        end else if (bus.min_tick) begin
          ring_cnt_d = ring_cnt_q + 4'd1;
        end else begin
          state_d = ST_RINGING;
        end
      end
      ST_SNOOZED: begin
        if (quit_s) begin
          state_d   = ST_IDLE;
          snz_cnt_d = 3'd0;
        end else if (snz_hit_s) begin
          state_d    = ST_RINGING;
          ring_cnt_d = 4'd0;
        end else begin
          state_d = ST_SNOOZED;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ring_cnt_d = 4'd0;
        snz_cnt_d  = 3'd0;
      end
    endcase
  end

  // State and output registers; outputs follow the next state so they lag inputs by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= 4'd0;
      snz_cnt_q  <= 3'd0;
      snz_min_q  <= 7'd0;
      snz_hrs_q  <= 7'd0;
      fired_q    <= 1'b0;
      buzz_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_min_q  <= snz_min_d;
      snz_hrs_q  <= snz_hrs_d;
      fired_q    <= fired_d;
      buzz_q     <= (state_d == ST_RINGING);
      snoozing_q <= (state_d == ST_SNOOZED);
    end
  end

  assign bus.buzz     = buzz_q;
  assign bus.snoozing = snoozing_q;
  assign bus.snz_min  = snz_min_q;
  assign bus.snz_hrs  = snz_hrs_q;
  assign bus.snz_cnt  = snz_cnt_q;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Sequencing controller for the alarm-clock buzzer path. It watches current time against the alarm setting and drives the buzzer through idle, ringing and snoozed phases. It handles stop and snooze requests, wraps snooze targets across the hour and day, and auto-silences after a ring timeout. It sits between the timekeeping counters (tmin/thrs, minute tick) and the buzzer output.

Parameters:
SNOOZE_MIN, 9, minutes added to current time on snooze (legal 1..59)
RING_MIN, 2, minute ticks the alarm rings before auto-silence (legal 1..15)
MAX_SNOOZE, 3, snoozes allowed per alarm event (legal 0..7)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
min_tick  input  1  one-cycle pulse; asserted in the first cycle tmin/thrs hold a new minute
tmin  input  7  current minutes, binary 0..59
thrs  input  7  current hours, binary 0..23
amin  input  7  alarm minutes, binary 0..59
ahrs  input  7  alarm hours, binary 0..23
alarm_en  input  1  alarm armed (level)
snooze  input  1  snooze request, one-cycle pulse
stop  input  1  stop request, one-cycle pulse
buzz  output  1  buzzer drive (registered)
snoozing  output  1  high while in SNOOZED (registered)
snz_min  output  7  snooze target minutes
snz_hrs  output  7  snooze target hours
snz_cnt  output  3  snoozes used in current alarm event

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. While reset=1 at a clk edge: state<=IDLE, buzz=0, snoozing=0, snz_min=0, snz_hrs=0, snz_cnt=0, ring_cnt=0, fired=0.
- All outputs are registered. An input event takes effect on outputs one cycle later.
- match = (tmin==amin)&&(thrs==ahrs).
- fired flag: set on IDLE->RINGING. Cleared on any cycle where match=0. This prevents re-trigger inside the same matching minute after stop, timeout or snooze.
- States: IDLE (buzz=0, snoozing=0), RINGING (buzz=1, snoozing=0), SNOOZED (buzz=0, snoozing=1).
- IDLE:
  - alarm_en && match && !fired -> RINGING; ring_cnt<=0; snz_cnt<=0.
  - Otherwise stay in IDLE.
- RINGING, first matching rule in priority order:
  1. stop || !alarm_en -> IDLE; snz_cnt<=0.
  2. snooze && snz_cnt<MAX_SNOOZE -> SNOOZED; snz_cnt<=snz_cnt+1; target latched from current tmin/thrs.
  3. snooze && snz_cnt==MAX_SNOOZE -> ignored; keep ringing, fall through to rule 4.
  4. min_tick && ring_cnt==RING_MIN-1 -> IDLE; snz_cnt<=0.
  5. min_tick otherwise -> ring_cnt<=ring_cnt+1.
- Snooze target arithmetic (8-bit intermediate):
  - m=tmin+SNOOZE_MIN. If m>=60: snz_min=m-60 and h=thrs+1, else snz_min=m and h=thrs.
  - snz_hrs = (h==24) ? 0 : h.
  - Example: 23:55 + 9 -> 00:04.
- SNOOZED, priority order:
  1. stop || !alarm_en -> IDLE; snz_cnt<=0.
  2. (tmin==snz_min)&&(thrs==snz_hrs) -> RINGING; ring_cnt<=0; snz_cnt unchanged.
  3. Otherwise stay. snooze pulses are ignored here. The original alarm match does not retrigger.
- snz_min/snz_hrs hold their value until the next snooze or reset.
- Simultaneous events:
  - stop+snooze in the same cycle: stop wins.
  - stop+timeout tick: IDLE either way.
  - snooze+timeout tick with snoozes left: SNOOZED.
  - alarm_en falling in any state: IDLE next cycle.
- Reset mid-ring or mid-snooze: buzz=0 and snoozing=0 in the cycle after the reset edge. fired is cleared, so if match still holds, alarm_en=1 and reset deasserts, the alarm re-triggers.
- Out-of-range time inputs (>59 min, >23 hr) are undefined use and are not checked.

Test Plan:
- Basic trigger and timeout: RING_MIN=2, alarm 07:30, time steps 07:29->07:30 with alarm_en=1 -> buzz=1 one cycle after 07:30 appears. Two further min_ticks (07:31, 07:32) -> buzz=0 one cycle after the second.
- Stop, no retrigger: ring at 07:30, stop pulse while time is still 07:30 -> buzz=0 next cycle and stays 0 through the rest of 07:30. A rearm at 07:30 the next day triggers again.
- Snooze with day wrap: alarm 23:55, snooze at 23:55 -> snoozing=1, snz_min=4, snz_hrs=0, snz_cnt=1. Time reaches 00:04 -> buzz=1, snoozing=0.
- Snooze limit: MAX_SNOOZE=1. First snooze -> SNOOZED. After re-ring, second snooze -> buzz stays 1, snz_cnt stays 1. Timeout -> IDLE with snz_cnt=0.
- Priority and disable: stop and snooze asserted together while ringing -> IDLE, snz_cnt=0. alarm_en dropped while SNOOZED -> IDLE; the snooze target time then passes with buzz=0.
- Reset mid-ring: reset pulse while buzz=1 -> all outputs reach reset values one cycle later. With time still matching, alarm_en=1 and reset released -> buzz=1 again one cycle after reset deasserts.
